// File: rtl/ascon_perm_unit.sv
// Ascon permutation coprocessor: 320-bit state behind a 32-bit word port, running p^a
// with ROUNDS_PER_CYCLE unrolled rounds per clock.
module ascon_perm_unit #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter bit          LOGIC_GATING     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [1:0]  op_i,
  input  logic [3:0]  idx_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  nrounds_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic [0:0] {StIdle, StRun} fsm_e;
  typedef logic [4:0][63:0] state_t;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpXor   = 2'b01;
  localparam logic [1:0] OpPerm  = 2'b10;
  localparam logic [1:0] OpRead  = 2'b11;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned p);
    return (v >> p) | (v << (64 - p));
  endfunction

  // One full round: constant add, bitsliced S-box, linear diffusion layer.
  function automatic state_t ascon_round(input state_t s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    state_t      o;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'h0, 4'hF - r, r};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    o[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    o[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    o[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    o[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return o;
  endfunction

  fsm_e        fsm_q, fsm_d;
  state_t      x_q, x_d, perm_out;
  logic [3:0]  rnd_q, rnd_d, rem_q, rem_d, step;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;

  logic        fire;
  logic [31:0] din;
  logic [3:0]  widx;
  logic [2:0]  lane;
  logic        idx_ok;
  logic [31:0] word_rd;
  logic [3:0]  nr_eff;

  assign ready_o  = (fsm_q == StIdle);
  assign busy_o   = ~ready_o;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign fire     = req_i & ready_o;

  if (LOGIC_GATING) begin : g_gate
    assign din  = data_i & {32{fire}};
    assign widx = idx_i & {4{fire}};
  end else begin : g_nogate
    assign din  = data_i;
    assign widx = idx_i;
  end

  assign lane   = widx[3:1];
  assign idx_ok = (widx < 4'd10);
  assign nr_eff = (nrounds_i > 4'd12) ? 4'd12 : nrounds_i;

  // The second unrolled round is only taken while at least two rounds remain.
  if (ROUNDS_PER_CYCLE == 2) begin : g_two
    state_t one_out, two_out;
    assign one_out  = ascon_round(x_q, rnd_q);
    assign two_out  = ascon_round(one_out, rnd_q + 4'd1);
    assign step     = (rem_q >= 4'd2) ? 4'd2 : 4'd1;
    assign perm_out = (step == 4'd2) ? two_out : one_out;
  end else begin : g_one
    assign step     = 4'd1;
    assign perm_out = ascon_round(x_q, rnd_q);
  end

  always_comb begin
    fsm_d    = fsm_q;
    x_d      = x_q;
    rnd_d    = rnd_q;
    rem_d    = rem_q;
    valid_d  = 1'b0;
    result_d = result_q;
    word_rd  = '0;
    if (idx_ok) begin
      word_rd = widx[0] ? x_q[lane][63:32] : x_q[lane][31:0];
    end
    unique case (fsm_q)
      StIdle: begin
        if (fire) begin
          unique case (op_i)
            OpWrite, OpXor: begin
              if (idx_ok) begin
                if (widx[0]) begin
                  x_d[lane][63:32] = (op_i == OpXor) ? (word_rd ^ din) : din;
                end else begin
                  x_d[lane][31:0] = (op_i == OpXor) ? (word_rd ^ din) : din;
                end
              end
            end
            OpRead: begin
              result_d = word_rd;
              valid_d  = 1'b1;
            end
            OpPerm: begin
              if (nr_eff == 4'd0) begin
                valid_d  = 1'b1;
                result_d = '0;
              end else begin
                rnd_d = 4'd12 - nr_eff;
                rem_d = nr_eff;
                fsm_d = StRun;
              end
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        x_d   = perm_out;
        rnd_d = rnd_q + step;
        rem_d = rem_q - step;
        if (rem_q == step) begin
          fsm_d    = StIdle;
          valid_d  = 1'b1;
          result_d = '0;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q    <= StIdle;
      x_q      <= '0;
      rnd_q    <= '0;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      x_q      <= x_d;
      rnd_q    <= rnd_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

endmodule
